control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
- REQ-001: clk  input  1  sole clock; all state changes on rising edge.
- REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising clk.
- REQ-003: ir  input  32  current instruction; opcode ir[31:27], immediate/offset ir[18:0].
- REQ-004: con_ff  input  1  branch-condition flag from datapath, valid in state EX4.
- REQ-005: mem_done  input  1  memory completion strobe; one-cycle pulse, any latency.
- REQ-006: Datapath strobes, output 1 bit each: PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, CONin, read, write.
- REQ-007: control  output  4  ALU operation code, driven to the datapath ALU.
- REQ-008: run  output  1  high while executing; low in HALT.
- REQ-009: state_dbg  output  4  current state encoding, for the bench.

Function
- REQ-010: States: FETCH0, FETCH1, FETCH2, EX0..EX4, HALT.
- REQ-011: FETCH0 shall assert PCout, MARin, IncPc, Zin; next FETCH1.
- REQ-012: FETCH1 shall assert Zlowout, PCin in its first cycle only; read and MDRin held every cycle until mem_done=1; leaves in the mem_done cycle; next FETCH2.
- REQ-013: FETCH2 shall assert MDRout, IRin; next EX0.
- REQ-014: ALU class (add, sub, and, or, shr, shl): EX0 Grb,Rout,Yin; EX1 Grc,Rout,Zin, control=op; EX2 Zlowout,Gra,Rin; then FETCH0.
- REQ-015: Immediate class (addi, andi, ori): same as REQ-014, but EX1 uses Cout instead of Grc,Rout.
- REQ-016: ld: EX0 Grb,BAout,Yin; EX1 Cout,Zin, control=ADD; EX2 Zlowout,MARin; EX3 read,MDRin held until mem_done; EX4 MDRout,Gra,Rin. ldi: EX0..EX1 as ld, then EX2 Zlowout,Gra,Rin.
- REQ-017: st: EX0..EX2 as ld; EX3 Gra,Rout,MDRin, read=0; EX4 write held until mem_done.
- REQ-018: br: EX0 Gra,Rout,CONin; EX1 PCout,Yin; EX2 Cout,Zin, control=ADD; EX3 no strobes; EX4 Zlowout,PCin only if con_ff=1.
- REQ-019: nop shall return from EX0 to FETCH0 with no strobes.
- REQ-020: halt shall go to HALT with run=0; HALT is left only by reset.
- REQ-021: Undefined opcodes shall execute as nop.
- REQ-022: Outputs are Moore, decoded from state and ir; at most one bus driver (*out strobe) is asserted per cycle.
- REQ-023: read and write are never high in the same cycle.
- REQ-024: mem_done outside a memory-wait state shall be ignored.

Reset
- REQ-025: reset shall force state FETCH0 and run=1, and deassert every strobe in that cycle, including mid-memory-wait.
- REQ-026: control shall reset to ALU_ADD; state_dbg shall reset to the FETCH0 encoding.

Configuration
- REQ-027: Macro CU_MULDIV_EN. When defined: mul and div take EX0 Gra,Rout,Yin; EX1 Grb,Rout,Zin, control=MUL/DIV; EX2 Zlowout,LOin; EX3 Zhighout,HIin; then FETCH0. When undefined: mul and div decode as nop.

Structure
- REQ-028: Package cpu_pkg shall hold the opcode constants (ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, br 10010, nop 11010, halt 11011), the ALU codes and the state enum.
- REQ-029: One sub-module, opcode_decoder, maps ir[31:27] to an instruction class; the FSM and strobe decode stay in control_sequencer.

Verification
- REQ-030: ir=0x18918000 (add r1,r2,r3), mem_done high in the first FETCH1 cycle -> FETCH0..EX2 in 6 cycles; Rin with Gra in cycle 6; control=ADD in EX1.
- REQ-031: mem_done delayed 3 cycles in FETCH1 -> read and MDRin high for 4 cycles; PCin high only in the first; then FETCH2.
- REQ-032: st, mem_done after 2 cycles in EX4 -> write high for 3 cycles; read stays 0 throughout.
- REQ-033: br with con_ff=0 -> no PCin in EX4; with con_ff=1 -> Zlowout,PCin in EX4.
- REQ-034: halt opcode 11011 -> run=0 and state HALT held for 20 cycles; reset pulse -> FETCH0, run=1.
- REQ-035: reset asserted mid-EX3 of ld -> next cycle all strobes 0, state FETCH0; mul with CU_MULDIV_EN undefined -> behaves as nop.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU codes, FSM states,
// instruction classes and the datapath strobe bundle.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_MUL = 4'd6,
    ALU_DIV = 4'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    FETCH0 = 4'd0,
    FETCH1 = 4'd1,
    FETCH2 = 4'd2,
    EX0    = 4'd3,
    EX1    = 4'd4,
    EX2    = 4'd5,
    EX3    = 4'd6,
    EX4    = 4'd7,
    HALT   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_IMM    = 4'd2,
    CLS_LD     = 4'd3,
    CLS_LDI    = 4'd4,
    CLS_ST     = 4'd5,
    CLS_BR     = 4'd6,
    CLS_MULDIV = 4'd7,
    CLS_HALT   = 4'd8
  } instr_class_e;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
    logic hi_out;
    logic lo_out;
    logic c_out;
    logic ba_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic con_in;
    logic read;
    logic write;
  } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath bundle: instruction/status inputs and all strobes.
// master = control sequencer, slave = datapath/memory side.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_done;

  logic PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout, CONin, read, write;

  logic [3:0] control;
  logic       run;
  logic [3:0] state_dbg;

  modport master (
    input  ir, con_ff, mem_done,
    output PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin,
    output Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout, BAout,
    output Gra, Grb, Grc, Rin, Rout, CONin, read, write,
    output control, run, state_dbg
  );

  modport slave (
    output ir, con_ff, mem_done,
    input  PCout, PCin, IncPc, MARin, MDRin, MDRout, IRin, Yin, Zin,
    input  Zlowout, Zhighout, HIin, LOin, HIout, LOout, Cout, BAout,
    input  Gra, Grb, Grc, Rin, Rout, CONin, read, write,
    input  control, run, state_dbg
  );
endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Maps the 5-bit opcode to an instruction class and its ALU operation.
// mul/div are recognised only when CU_MULDIV_EN is defined; otherwise they fall to nop.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [4:0]   i_opcode,
  output instr_class_e o_class,
  output alu_op_e      o_alu_op
);

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    o_class  = CLS_NOP;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_LD:   o_class = CLS_LD;
      OP_LDI:  o_class = CLS_LDI;
      OP_ST:   o_class = CLS_ST;
      OP_ADD:  o_class = CLS_ALU;
      OP_SUB:  begin o_class = CLS_ALU; o_alu_op = ALU_SUB; end
      OP_AND:  begin o_class = CLS_ALU; o_alu_op = ALU_AND; end
      OP_OR:   begin o_class = CLS_ALU; o_alu_op = ALU_OR;  end
      OP_SHR:  begin o_class = CLS_ALU; o_alu_op = ALU_SHR; end
      OP_SHL:  begin o_class = CLS_ALU; o_alu_op = ALU_SHL; end
      OP_ADDI: o_class = CLS_IMM;
      OP_ANDI: begin o_class = CLS_IMM; o_alu_op = ALU_AND; end
      OP_ORI:  begin o_class = CLS_IMM; o_alu_op = ALU_OR;  end
`ifdef CU_MULDIV_EN
      OP_MUL:  begin o_class = CLS_MULDIV; o_alu_op = ALU_MUL; end
      OP_DIV:  begin o_class = CLS_MULDIV; o_alu_op = ALU_DIV; end
`endif
      OP_BR:   o_class = CLS_BR;
      OP_NOP:  o_class = CLS_NOP;
      OP_HALT: o_class = CLS_HALT;
      default: o_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch/execute FSM driving datapath strobes from state and ir.
// Optional mul/div microcode is enabled by CU_MULDIV_EN (see opcode_decoder).
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  instr_class_e w_class;
  alu_op_e      w_alu_op;
  alu_op_e      w_control;
  state_e       r_state;
  state_e       w_next;
  strobes_t     w_strb;
  logic         r_fetch1_wait;
  logic         w_unused_ir;

  // Only the opcode field matters here; the offset bits feed the datapath directly.
  assign w_unused_ir = ^bus.ir[26:0];

  opcode_decoder u_opcode_decoder (
    .i_opcode (bus.ir[31:27]),
    .o_class  (w_class),
    .o_alu_op (w_alu_op)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH0;
      r_fetch1_wait <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_fetch1_wait <= (r_state == FETCH1) && !bus.mem_done;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_strb    = '0;
    w_control = ALU_ADD;
    case (r_state)
      FETCH0: begin
        w_strb.pc_out = 1'b1;
        w_strb.mar_in = 1'b1;
        w_strb.inc_pc = 1'b1;
        w_strb.z_in   = 1'b1;
        w_next        = FETCH1;
      end
      FETCH1: begin
        w_strb.read   = 1'b1;
        w_strb.mdr_in = 1'b1;
        // The incremented PC is written back once, not on every wait cycle.
        if (!r_fetch1_wait) begin
          w_strb.zlow_out = 1'b1;
          w_strb.pc_in    = 1'b1;
        end
        if (bus.mem_done) w_next = FETCH2;
      end
      FETCH2: begin
        w_strb.mdr_out = 1'b1;
        w_strb.ir_in   = 1'b1;
        w_next         = EX0;
      end
      EX0: begin
        case (w_class)
          CLS_ALU, CLS_IMM: begin
            w_strb.grb   = 1'b1;
            w_strb.r_out = 1'b1;
            w_strb.y_in  = 1'b1;
            w_next       = EX1;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            w_strb.grb    = 1'b1;
            w_strb.ba_out = 1'b1;
            w_strb.y_in   = 1'b1;
            w_next        = EX1;
          end
          CLS_BR: begin
            w_strb.gra    = 1'b1;
            w_strb.r_out  = 1'b1;
            w_strb.con_in = 1'b1;
            w_next        = EX1;
          end
          CLS_MULDIV: begin
            w_strb.gra   = 1'b1;
            w_strb.r_out = 1'b1;
            w_strb.y_in  = 1'b1;
            w_next       = EX1;
          end
          CLS_HALT: w_next = HALT;
          default:  w_next = FETCH0;
        endcase
      end
      EX1: begin
        w_next = EX2;
        case (w_class)
          CLS_ALU: begin
            w_strb.grc   = 1'b1;
            w_strb.r_out = 1'b1;
            w_strb.z_in  = 1'b1;
            w_control    = w_alu_op;
          end
          CLS_IMM: begin
            w_strb.c_out = 1'b1;
            w_strb.z_in  = 1'b1;
            w_control    = w_alu_op;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            w_strb.c_out = 1'b1;
            w_strb.z_in  = 1'b1;
          end
          CLS_BR: begin
            w_strb.pc_out = 1'b1;
            w_strb.y_in   = 1'b1;
          end
          CLS_MULDIV: begin
            w_strb.grb   = 1'b1;
            w_strb.r_out = 1'b1;
            w_strb.z_in  = 1'b1;
            w_control    = w_alu_op;
          end
          default: w_next = FETCH0;
        endcase
      end
      EX2: begin
        w_next = FETCH0;
        case (w_class)
          CLS_ALU, CLS_IMM, CLS_LDI: begin
            w_strb.zlow_out = 1'b1;
            w_strb.gra      = 1'b1;
            w_strb.r_in     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            w_strb.zlow_out = 1'b1;
            w_strb.mar_in   = 1'b1;
            w_next          = EX3;
          end
          CLS_BR: begin
            w_strb.c_out = 1'b1;
            w_strb.z_in  = 1'b1;
            w_next       = EX3;
          end
          CLS_MULDIV: begin
            w_strb.zlow_out = 1'b1;
            w_strb.lo_in    = 1'b1;
            w_next          = EX3;
          end
          default: w_next = FETCH0;
        endcase
      end
      EX3: begin
        w_next = FETCH0;
        case (w_class)
          CLS_LD: begin
            w_strb.read   = 1'b1;
            w_strb.mdr_in = 1'b1;
            w_next        = bus.mem_done ? EX4 : EX3;
          end
          CLS_ST: begin
            w_strb.gra    = 1'b1;
            w_strb.r_out  = 1'b1;
            w_strb.mdr_in = 1'b1;
            w_next        = EX4;
          end
          CLS_BR: w_next = EX4;
          CLS_MULDIV: begin
            w_strb.zhigh_out = 1'b1;
            w_strb.hi_in     = 1'b1;
          end
          default: w_next = FETCH0;
        endcase
      end
      EX4: begin
        w_next = FETCH0;
        case (w_class)
          CLS_LD: begin
            w_strb.mdr_out = 1'b1;
            w_strb.gra     = 1'b1;
            w_strb.r_in    = 1'b1;
          end
          CLS_ST: begin
            w_strb.write = 1'b1;
            w_next       = bus.mem_done ? FETCH0 : EX4;
          end
          CLS_BR: begin
            w_strb.zlow_out = bus.con_ff;
            w_strb.pc_in    = bus.con_ff;
          end
          default: w_next = FETCH0;
        endcase
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH0;
    endcase

    // Reset silences the datapath immediately, even in the middle of a memory wait.
    if (reset) begin
      w_strb    = '0;
      w_control = ALU_ADD;
    end
  end

  assign bus.PCout     = w_strb.pc_out;
  assign bus.PCin      = w_strb.pc_in;
  assign bus.IncPc     = w_strb.inc_pc;
  assign bus.MARin     = w_strb.mar_in;
  assign bus.MDRin     = w_strb.mdr_in;
  assign bus.MDRout    = w_strb.mdr_out;
  assign bus.IRin      = w_strb.ir_in;
  assign bus.Yin       = w_strb.y_in;
  assign bus.Zin       = w_strb.z_in;
  assign bus.Zlowout   = w_strb.zlow_out;
  assign bus.Zhighout  = w_strb.zhigh_out;
  assign bus.HIin      = w_strb.hi_in;
  assign bus.LOin      = w_strb.lo_in;
  assign bus.HIout     = w_strb.hi_out;
  assign bus.LOout     = w_strb.lo_out;
  assign bus.Cout      = w_strb.c_out;
  assign bus.BAout     = w_strb.ba_out;
  assign bus.Gra       = w_strb.gra;
  assign bus.Grb       = w_strb.grb;
  assign bus.Grc       = w_strb.grc;
  assign bus.Rin       = w_strb.r_in;
  assign bus.Rout      = w_strb.r_out;
  assign bus.CONin     = w_strb.con_in;
  assign bus.read      = w_strb.read;
  assign bus.write     = w_strb.write;
  assign bus.control   = w_control;
  assign bus.run       = reset || (r_state != HALT);
  assign bus.state_dbg = r_state;

endmodule
